// File: rtl/range_finder.sv
// Streaming unsigned min/max tracker: a go..finish run registers max-min on range.
// Optional build macro RANGE_CLEAR_ON_ERROR_EN clears range on every entry into ERROR.
module range_finder #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             go,
  input  logic             finish,
  output logic [WIDTH-1:0] range,
  output logic             debug_error
);

`ifdef RANGE_CLEAR_ON_ERROR_EN
  localparam bit CLEAR_ON_ERROR = 1'b1;
`else
  localparam bit CLEAR_ON_ERROR = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic [WIDTH-1:0] range_q, range_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] max_s, min_s;
  logic             start_s;

  assign start_s = go && !finish;
  assign range       = range_q;
  assign debug_error = err_q;

  // Running extremes including the current sample
  always_comb begin
    max_s = (data_in > high_q) ? data_in : high_q;
    min_s = (data_in < low_q)  ? data_in : low_q;
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      high_q  <= '0;
      low_q   <= '1;
      range_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      high_q  <= high_d;
      low_q   <= low_d;
      range_q <= range_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (finish)       state_d = S_ERROR;
        else if (go)      state_d = S_RUN;
        else              state_d = S_IDLE;
      end
      S_RUN: begin
        if (go && finish) state_d = S_ERROR;
        else if (finish)  state_d = S_IDLE;
        else              state_d = S_RUN;
      end
      S_ERROR: begin
        if (start_s)      state_d = S_RUN;
        else              state_d = S_ERROR;
      end
      default:            state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    high_d  = high_q;
    low_d   = low_q;
    range_d = range_q;
    case (state_q)
      S_IDLE, S_ERROR: begin
        if (start_s) begin
          high_d = data_in;
          low_d  = data_in;
        end else begin
          high_d = high_q;
        end
      end
      S_RUN: begin
        if (start_s) begin
          high_d = data_in;
          low_d  = data_in;
        end else if (!go && finish) begin
          high_d  = max_s;
          low_d   = min_s;
          range_d = max_s - min_s;
        end else if (!go) begin
          high_d = max_s;
          low_d  = min_s;
        end else begin
          range_d = range_q;
        end
      end
      default: begin
        high_d = high_q;
      end
    endcase
    // Only a transition into ERROR clears; staying there keeps the (already cleared) value
    if (CLEAR_ON_ERROR && (state_d == S_ERROR) && (state_q != S_ERROR)) begin
      range_d = '0;
    end else begin
      range_d = range_d;
    end
    err_d = (state_d == S_ERROR);
  end

endmodule

// File: tb/tb_range_finder.sv
// Self-checking bench for range_finder using a scoreboard queue of expected outputs.
module tb_range_finder;

`ifdef RANGE_CLEAR_ON_ERROR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  typedef struct {
    logic [15:0] rng;
    logic        err;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [15:0] data_in;
  logic        go;
  logic        finish;
  logic [15:0] range;
  logic        debug_error;

  exp_t sb_q[$];
  int   tests;
  int   fails;

  range_finder #(.WIDTH(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .go         (go),
    .finish     (finish),
    .range      (range),
    .debug_error(debug_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic apply(input logic [15:0] d, input logic g, input logic f);
    data_in = d;
    go      = g;
    finish  = f;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b0; data_in = 16'h0; go = 1'b0; finish = 1'b0;
    sb_q.push_back('{rng: 16'h0000, err: 1'b0});
    @(posedge clock); #1;
    @(posedge clock); #1;
    e = sb_q.pop_front(); tests++;
    if (range !== e.rng || debug_error !== e.err) begin
      fails++;
      $display("FAIL reset: range=%h err=%b expected range=%h err=%b", range, debug_error, e.rng, e.err);
    end
    reset = 1'b1;
  endtask

  task automatic test_run();
    logic [15:0] d[6], er[6];
    logic g[6], f[6];
    exp_t e;
    d  = '{16'h7FFF, 16'h8000, 16'h8001, 16'h7FFE, 16'h7FFF, 16'h7FFF};
    g  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    f  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    er = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0003};
    for (int i = 0; i < 6; i++) begin
      sb_q.push_back('{rng: er[i], err: 1'b0});
      apply(d[i], g[i], f[i]);
      e = sb_q.pop_front(); tests++;
      if (range !== e.rng || debug_error !== e.err) begin
        fails++;
        $display("FAIL run[%0d]: range=%h err=%b expected range=%h err=%b", i, range, debug_error, e.rng, e.err);
      end
    end
  endtask

  task automatic test_error_both();
    logic [15:0] r0;
    exp_t e;
    r0 = CLR ? 16'h0000 : 16'h0003;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{rng: r0, err: 1'b1});
      apply(16'h1234, (i == 0), (i == 0));
      e = sb_q.pop_front(); tests++;
      if (range !== e.rng || debug_error !== e.err) begin
        fails++;
        $display("FAIL go_finish_idle[%0d]: range=%h err=%b expected range=%h err=%b", i, range, debug_error, e.rng, e.err);
      end
    end
  endtask

  task automatic test_recover();
    logic [15:0] d[4], er[4];
    logic [15:0] r0;
    exp_t e;
    r0 = CLR ? 16'h0000 : 16'h0003;
    d  = '{16'h0100, 16'h0000, 16'hFFFF, 16'h0200};
    er = '{r0, r0, r0, 16'hFFFF};
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back('{rng: er[i], err: 1'b0});
      apply(d[i], (i == 0), (i == 3));
      e = sb_q.pop_front(); tests++;
      if (range !== e.rng || debug_error !== e.err) begin
        fails++;
        $display("FAIL recover_full_scale[%0d]: range=%h err=%b expected range=%h err=%b", i, range, debug_error, e.rng, e.err);
      end
    end
  endtask

  task automatic test_finish_alone();
    logic [15:0] r1;
    logic f[3];
    exp_t e;
    r1 = CLR ? 16'h0000 : 16'hFFFF;
    f  = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{rng: r1, err: 1'b1});
      apply(16'h0000, 1'b0, f[i]);
      e = sb_q.pop_front(); tests++;
      if (range !== e.rng || debug_error !== e.err) begin
        fails++;
        $display("FAIL finish_alone[%0d]: range=%h err=%b expected range=%h err=%b", i, range, debug_error, e.rng, e.err);
      end
    end
    // single-sample run straight out of ERROR
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back('{rng: (i == 0) ? r1 : 16'h0000, err: 1'b0});
      apply(16'h0010, (i == 0), (i == 1));
      e = sb_q.pop_front(); tests++;
      if (range !== e.rng || debug_error !== e.err) begin
        fails++;
        $display("FAIL single_sample[%0d]: range=%h err=%b expected range=%h err=%b", i, range, debug_error, e.rng, e.err);
      end
    end
  endtask

  task automatic test_restart();
    logic [15:0] d[5], er[5];
    logic g[5];
    exp_t e;
    d  = '{16'h0005, 16'h0100, 16'h0050, 16'h0060, 16'h0055};
    g  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    er = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0010};
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back('{rng: er[i], err: 1'b0});
      apply(d[i], g[i], (i == 4));
      e = sb_q.pop_front(); tests++;
      if (range !== e.rng || debug_error !== e.err) begin
        fails++;
        $display("FAIL restart[%0d]: range=%h err=%b expected range=%h err=%b", i, range, debug_error, e.rng, e.err);
      end
    end
  endtask

  task automatic test_run_go_finish();
    logic [15:0] d[4], er[4];
    logic g[4], f[4], ee[4];
    logic [15:0] r2;
    exp_t e;
    r2 = CLR ? 16'h0000 : 16'h0010;
    d  = '{16'h0001, 16'h0009, 16'h0003, 16'h0000};
    g  = '{1'b1, 1'b0, 1'b1, 1'b0};
    f  = '{1'b0, 1'b0, 1'b1, 1'b0};
    er = '{16'h0010, 16'h0010, r2, r2};
    ee = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back('{rng: er[i], err: ee[i]});
      apply(d[i], g[i], f[i]);
      e = sb_q.pop_front(); tests++;
      if (range !== e.rng || debug_error !== e.err) begin
        fails++;
        $display("FAIL run_go_finish[%0d]: range=%h err=%b expected range=%h err=%b", i, range, debug_error, e.rng, e.err);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d_q[$], r_q[$];
    logic g_q[$], f_q[$];
    logic [15:0] prev, hi, lo, s;
    int n;
    exp_t e;
    prev = CLR ? 16'h0000 : 16'h0010;
    for (int r = 0; r < 8; r++) begin
      s = 16'($urandom);
      d_q.push_back(s); g_q.push_back(1'b1); f_q.push_back(1'b0); r_q.push_back(prev);
      hi = s; lo = s;
      n = $urandom_range(0, 5);
      for (int k = 0; k < n; k++) begin
        s = 16'($urandom);
        d_q.push_back(s); g_q.push_back(1'b0); f_q.push_back(1'b0); r_q.push_back(prev);
        if (s > hi) hi = s;
        if (s < lo) lo = s;
      end
      s = 16'($urandom);
      if (s > hi) hi = s;
      if (s < lo) lo = s;
      prev = hi - lo;
      d_q.push_back(s); g_q.push_back(1'b0); f_q.push_back(1'b1); r_q.push_back(prev);
      if ($urandom_range(0, 1) == 1) begin
        d_q.push_back(16'($urandom)); g_q.push_back(1'b0); f_q.push_back(1'b0); r_q.push_back(prev);
      end
    end
    for (int i = 0; i < d_q.size(); i++) begin
      sb_q.push_back('{rng: r_q[i], err: 1'b0});
      apply(d_q[i], g_q[i], f_q[i]);
      e = sb_q.pop_front(); tests++;
      if (range !== e.rng || debug_error !== e.err) begin
        fails++;
        $display("FAIL back_to_back[%0d]: range=%h err=%b expected range=%h err=%b", i, range, debug_error, e.rng, e.err);
      end
    end
  endtask

  task automatic test_reset_midrun();
    exp_t e;
    apply(16'h1234, 1'b1, 1'b0);
    apply(16'h2000, 1'b0, 1'b0);
    go = 1'b0; finish = 1'b0;
    reset = 1'b0;
    sb_q.push_back('{rng: 16'h0000, err: 1'b0});
    #1;
    e = sb_q.pop_front(); tests++;
    if (range !== e.rng || debug_error !== e.err) begin
      fails++;
      $display("FAIL reset_async: range=%h err=%b expected range=%h err=%b", range, debug_error, e.rng, e.err);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    sb_q.push_back('{rng: 16'h0000, err: 1'b1});
    apply(16'h0050, 1'b0, 1'b1);
    e = sb_q.pop_front(); tests++;
    if (range !== e.rng || debug_error !== e.err) begin
      fails++;
      $display("FAIL finish_after_reset: range=%h err=%b expected range=%h err=%b", range, debug_error, e.rng, e.err);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_run();
    test_error_both();
    test_recover();
    test_finish_alone();
    test_restart();
    test_run_go_finish();
    test_back_to_back();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
